// File: rtl/mouse_cursor_overlay_pkg.sv
// Shared VGA constants, cursor sprite codes and the arrow bitmap used by the overlay.
package mouse_cursor_overlay_pkg;

  localparam int COLOR_W   = 8;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int CUR_SIZE  = 16;
  localparam int CUR_BITS  = $clog2(CUR_SIZE);

  typedef logic [1:0] cur_code_t;

  localparam cur_code_t CUR_TRANSPARENT = 2'b00;
  localparam cur_code_t CUR_OUTLINE     = 2'b01;
  localparam cur_code_t CUR_FILL        = 2'b10;
  localparam cur_code_t CUR_INVERT      = 2'b11;

  // RGB332 field accessors.
  function automatic logic [2:0] rgb332_red(input logic [7:0] c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb332_green(input logic [7:0] c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb332_blue(input logic [7:0] c);
    return c[1:0];
  endfunction

  // Arrow: outlined triangle in rows 0..11, an inverting stem block in rows 12..15.
  function automatic cur_code_t cursor_arrow_code(input logic [3:0] row, input logic [3:0] col);
    cur_code_t code;
    if (row < 4'd12) begin
      if ((col == 4'd0) || (col == row)) begin
        code = CUR_OUTLINE;
      end else if (col < row) begin
        code = CUR_FILL;
      end else begin
        code = CUR_TRANSPARENT;
      end
    end else begin
      if (col < 4'd4) begin
        code = CUR_INVERT;
      end else begin
        code = CUR_TRANSPARENT;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/mouse_cursor_overlay_if.sv
// Pixel stream into the overlay and the final colour/sync stream out to the DAC.
interface mouse_cursor_overlay_if #(
  parameter int COLOR_W = 8
);
  logic               pixel_tick;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               video_on;
  logic               hsync_in;
  logic               vsync_in;
  logic [COLOR_W-1:0] bg_color;
  logic [COLOR_W-1:0] rgb;
  logic               hsync_out;
  logic               vsync_out;

  modport master (
    output pixel_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, bg_color,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  pixel_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, bg_color,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/mouse_cursor_overlay_sprite_rom.sv
// 256x2 cursor bitmap with a one-tick synchronous read, addressed {row, col}.
module cursor_sprite_rom
  import mouse_cursor_overlay_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_en,
  input  logic [7:0] i_addr,
  output cur_code_t o_code
);

  cur_code_t r_code;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_code <= CUR_TRANSPARENT;
    end else if (i_en) begin
      r_code <= cursor_arrow_code(i_addr[7:4], i_addr[3:0]);
    end
  end

  assign o_code = r_code;

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Overlays a 16x16 cursor sprite on the background and delays syncs to match the
// two-tick colour pipeline. Cursor moves only take effect at the frame boundary.
module mouse_cursor_overlay
  import mouse_cursor_overlay_pkg::*;
#(
  parameter logic [COLOR_W-1:0] COL_OUTLINE      = 8'h00,
  parameter logic [COLOR_W-1:0] COL_FILL         = 8'hFF,
  parameter logic [COLOR_W-1:0] COL_FILL_PRESSED = 8'hE0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mouse_cursor_overlay_if.slave vga,
  input  logic [9:0]            i_cursor_x,
  input  logic [9:0]            i_cursor_y,
  input  logic                  i_cursor_update,
  input  logic [2:0]            i_buttons
);

  localparam logic [9:0] X_MAX    = 10'(H_DISPLAY - 1);
  localparam logic [9:0] Y_MAX    = 10'(V_DISPLAY - 1);
  localparam logic [9:0] Y_COMMIT = 10'(V_DISPLAY);

  logic [9:0]         r_pend_x, r_pend_y, r_act_x, r_act_y;
  logic [2:0]         r_btn_pend;
  logic               r_btn_act;
  logic               r_video_d1, r_hs_d1, r_vs_d1, r_inbox_d1;
  logic [COLOR_W-1:0] r_bg_d1;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_hs, r_vs;

  logic [9:0]          w_clamp_x, w_clamp_y;
  logic                w_commit;
  logic [10:0]         w_px_ext, w_py_ext, w_ax_ext, w_ay_ext;
  logic                w_in_box;
  logic [CUR_BITS-1:0] w_dx, w_dy;
  logic [7:0]          w_addr;
  cur_code_t           w_code;
  logic [COLOR_W-1:0]  w_rgb_next;

  assign w_clamp_x = (i_cursor_x > X_MAX) ? X_MAX : i_cursor_x;
  assign w_clamp_y = (i_cursor_y > Y_MAX) ? Y_MAX : i_cursor_y;
  assign w_commit  = vga.pixel_tick && (vga.pixel_x == 10'd0) && (vga.pixel_y == Y_COMMIT);

  // Non-blocking update means a coincident CursorUpdate is only seen at the next commit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend_x   <= 10'd0;
      r_pend_y   <= 10'd0;
      r_act_x    <= 10'd0;
      r_act_y    <= 10'd0;
      r_btn_pend <= 3'd0;
      r_btn_act  <= 1'b0;
    end else begin
      r_btn_pend <= i_buttons;
      if (i_cursor_update) begin
        r_pend_x <= w_clamp_x;
        r_pend_y <= w_clamp_y;
      end
      if (w_commit) begin
        r_act_x   <= r_pend_x;
        r_act_y   <= r_pend_y;
        r_btn_act <= |r_btn_pend;
      end
    end
  end

  // 11-bit compares so a cursor near the right/bottom edge never wraps to 0.
  assign w_px_ext = {1'b0, vga.pixel_x};
  assign w_py_ext = {1'b0, vga.pixel_y};
  assign w_ax_ext = {1'b0, r_act_x};
  assign w_ay_ext = {1'b0, r_act_y};
  assign w_in_box = (w_px_ext >= w_ax_ext) && (w_px_ext < (w_ax_ext + 11'(CUR_SIZE))) &&
                    (w_py_ext >= w_ay_ext) && (w_py_ext < (w_ay_ext + 11'(CUR_SIZE)));
  assign w_dx     = CUR_BITS'(vga.pixel_x) - CUR_BITS'(r_act_x);
  assign w_dy     = CUR_BITS'(vga.pixel_y) - CUR_BITS'(r_act_y);
  assign w_addr   = {w_dy, w_dx};

  cursor_sprite_rom u_rom (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (vga.pixel_tick),
    .i_addr  (w_addr),
    .o_code  (w_code)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_video_d1 <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_inbox_d1 <= 1'b0;
      r_bg_d1    <= {COLOR_W{1'b0}};
    end else if (vga.pixel_tick) begin
      r_video_d1 <= vga.video_on;
      r_hs_d1    <= vga.hsync_in;
      r_vs_d1    <= vga.vsync_in;
      r_inbox_d1 <= w_in_box;
      r_bg_d1    <= vga.bg_color;
    end
  end

  always_comb begin
    w_rgb_next = r_bg_d1;
    if (!r_video_d1) begin
      w_rgb_next = {COLOR_W{1'b0}};
    end else if (!r_inbox_d1) begin
      w_rgb_next = r_bg_d1;
    end else begin
      case (w_code)
        CUR_OUTLINE: w_rgb_next = COL_OUTLINE;
        CUR_FILL:    w_rgb_next = r_btn_act ? COL_FILL_PRESSED : COL_FILL;
        CUR_INVERT:  w_rgb_next = ~r_bg_d1;
        default:     w_rgb_next = r_bg_d1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rgb <= {COLOR_W{1'b0}};
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else if (vga.pixel_tick) begin
      r_rgb <= w_rgb_next;
      r_hs  <= r_hs_d1;
      r_vs  <= r_vs_d1;
    end
  end

  assign vga.rgb       = r_rgb;
  assign vga.hsync_out = r_hs;
  assign vga.vsync_out = r_vs;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Directed bench: driver pushes hand-computed expectations, a monitor pops and compares.
module tb_mouse_cursor_overlay;
  import mouse_cursor_overlay_pkg::*;

  typedef struct {
    int         idx;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] cur_x, cur_y;
  logic       cur_upd;
  logic [2:0] buttons;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issue  = 0;
  int   ticks_seen = 0;

  always #10 clk = ~clk;

  mouse_cursor_overlay_if #(.COLOR_W(COLOR_W)) vga ();

  mouse_cursor_overlay dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .vga             (vga),
    .i_cursor_x      (cur_x),
    .i_cursor_y      (cur_y),
    .i_cursor_update (cur_upd),
    .i_buttons       (buttons)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One pixel on one tick; the expected output is queued when reset is released.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                     input logic hs, input logic vs, input logic [7:0] bg,
                     input logic [7:0] e_rgb, input string name, input logic upd = 1'b0);
    @(negedge clk);
    vga.pixel_x    = x;
    vga.pixel_y    = y;
    vga.video_on   = von;
    vga.hsync_in   = hs;
    vga.vsync_in   = vs;
    vga.bg_color   = bg;
    vga.pixel_tick = 1'b1;
    cur_upd        = upd;
    if (rst_n) begin
      n_issue++;
      q.push_back(exp_t'{n_issue, e_rgb, hs, vs, name});
    end
    @(negedge clk);
    vga.pixel_tick = 1'b0;
    cur_upd        = 1'b0;
  endtask

  task automatic move_cursor(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    cur_x   = x;
    cur_y   = y;
    cur_upd = 1'b1;
    @(negedge clk);
    cur_upd = 1'b0;
  endtask

  task automatic commit(input string name);
    pix(10'd0, 10'd480, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, name);
  endtask

  // Monitor: output after tick N reflects the pixel issued on tick N-1.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (vga.pixel_tick === 1'b1 && rst_n === 1'b1) begin
        ticks_seen++;
        #1;
        while (q.size() > 0 && (q[0].idx + 1) < ticks_seen) begin
          e = q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL %s: output never compared, expected rgb %0h", e.name, e.rgb);
        end
        if (q.size() > 0 && (q[0].idx + 1) == ticks_seen) begin
          e = q.pop_front();
          check({e.name, "_rgb"}, 32'(vga.rgb), 32'(e.rgb));
          check({e.name, "_hs"}, 32'(vga.hsync_out), 32'(e.hs));
          check({e.name, "_vs"}, 32'(vga.vsync_out), 32'(e.vs));
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    cur_x          = 10'd0;
    cur_y          = 10'd0;
    cur_upd        = 1'b0;
    buttons        = 3'd0;
    vga.pixel_tick = 1'b0;
    vga.pixel_x    = 10'd0;
    vga.pixel_y    = 10'd0;
    vga.video_on   = 1'b0;
    vga.hsync_in   = 1'b0;
    vga.vsync_in   = 1'b0;
    vga.bg_color   = 8'h00;

    // Reset held for three ticks with live inputs: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      pix(10'd320, 10'd240, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, "rst");
      check("reset_rgb", 32'(vga.rgb), 32'h0);
      check("reset_hs", 32'(vga.hsync_out), 32'h0);
      check("reset_vs", 32'(vga.vsync_out), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    pix(10'd320, 10'd240, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "bg_after_reset");
    pix(10'd0,   10'd0,   1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "origin_cursor");

    // Mid-frame move must not show until the commit tick.
    move_cursor(10'd100, 10'd50);
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "no_tear");
    pix(10'd0,   10'd0,  1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "old_pos_kept");
    commit("commit1");
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "new_outline");
    pix(10'd116, 10'd50, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "right_of_box");
    pix(10'd115, 10'd50, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "transparent");
    pix(10'd101, 10'd52, 1'b1, 1'b0, 1'b0, 8'h55, 8'hFF, "fill_released");
    pix(10'd100, 10'd62, 1'b1, 1'b0, 1'b0, 8'h12, 8'hED, "invert");
    pix(10'd0,   10'd0,  1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "origin_cleared");

    // Horizontal sync pulse across 656..751 in blanking.
    for (int x = 654; x < 754; x++) begin
      pix(10'(x), 10'd100, 1'b0, ((x >= 656) && (x <= 751)), 1'b0, 8'h55, 8'h00, "hsync");
    end
    // Vertical sync pulse on rows 490..491.
    for (int y = 488; y < 494; y++) begin
      pix(10'd5, 10'(y), 1'b0, 1'b0, ((y >= 490) && (y <= 491)), 8'h55, 8'h00, "vsync");
    end

    // Buttons apply only at commit and select the pressed fill colour.
    buttons = 3'b001;
    commit("commit_btn");
    pix(10'd101, 10'd52, 1'b1, 1'b0, 1'b0, 8'h12, 8'hE0, "fill_pressed");
    pix(10'd100, 10'd62, 1'b1, 1'b0, 1'b0, 8'h12, 8'hED, "invert_pressed");
    pix(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 8'h12, 8'h00, "outline_pressed");
    buttons = 3'b000;
    pix(10'd101, 10'd52, 1'b1, 1'b0, 1'b0, 8'h12, 8'hE0, "fill_held_in_frame");
    commit("commit_nobtn");
    pix(10'd101, 10'd52, 1'b1, 1'b0, 1'b0, 8'h12, 8'hFF, "fill_unpressed");

    // Out-of-range request clamps to the bottom-right pixel, no wrap.
    move_cursor(10'd700, 10'd600);
    commit("commit_clamp");
    pix(10'd639, 10'd479, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "clamp_corner");
    pix(10'd638, 10'd479, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "clamp_left");
    pix(10'd0,   10'd0,   1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "clamp_no_wrap_xy");
    pix(10'd639, 10'd0,   1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "clamp_no_wrap_y");
    pix(10'd0,   10'd479, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "clamp_no_wrap_x");
    pix(10'd640, 10'd479, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, "clip_blank");

    // Update on the commit tick itself is deferred by one frame.
    cur_x = 10'd200;
    cur_y = 10'd100;
    pix(10'd0, 10'd480, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, "commit_with_upd", 1'b1);
    pix(10'd639, 10'd479, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "coinc_old_pos");
    pix(10'd200, 10'd100, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "coinc_new_absent");
    commit("commit_after");
    pix(10'd200, 10'd100, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "coinc_new_pos");
    pix(10'd639, 10'd479, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, "coinc_old_gone");

    // One extra tick pushes the last pixel out; nothing may stay queued.
    @(negedge clk);
    vga.pixel_tick = 1'b1;
    n_issue++;
    @(negedge clk);
    vga.pixel_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
